gray_step_ctrl: RTL and testbench

Two-requester scheduler that shares one 3-bit Gray counter (sync active-high clear, enable, sticky overflow) between clients. It accepts "optionally clear, then advance N steps" commands with round-robin arbitration, drives the counter's clear and enable lines, and returns the final Gray value and overflow status. It sits between the client logic and the Gray counter instance.

---
 rtl/gray_step_ctrl.sv | 158 +++++++++++++++
 tb/tb_gray_step_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_ctrl.sv
// Round-robin scheduler sharing one Gray counter between two requesters:
// each command optionally clears the counter, advances it N steps, then reports the value.
module gray_step_ctrl #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Cmd0,
  input  logic [STEP_W-1:0] Steps0,
  input  logic              Req1,
  input  logic              Cmd1,
  input  logic [STEP_W-1:0] Steps1,
  input  logic [2:0]        GrayIn,
  input  logic              OvfIn,
  output logic              CntClr,
  output logic              CntEn,
  output logic [1:0]        Gnt,
  output logic              Owner,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        Result,
  output logic              OvfFlag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [STEP_W-1:0] L_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [STEP_W-1:0] r_remaining;
  logic [STEP_W-1:0] w_remaining;
  logic              r_last;
  logic              w_idx;
  logic              w_accept;
  logic              w_cmd;
  logic [STEP_W-1:0] w_steps;
  logic              r_cnt_clr;
  logic              r_cnt_en;
  logic [1:0]        r_gnt;
  logic              r_owner;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_result;
  logic              r_ovf;

  // Arbitration, next-state and step-count decrement.
  always_comb begin
    w_next      = r_state;
    w_remaining = r_remaining;
    w_accept    = 1'b0;
    w_idx       = 1'b0;
    if (Req0 && Req1) begin
      w_idx = ~r_last;
    end else if (Req1) begin
      w_idx = 1'b1;
    end else begin
      w_idx = 1'b0;
    end
    w_cmd   = w_idx ? Cmd1 : Cmd0;
    w_steps = w_idx ? Steps1 : Steps0;
    case (r_state)
      S_IDLE: begin
        if (Req0 || Req1) begin
          w_accept    = 1'b1;
          w_remaining = w_steps;
          if (w_cmd) begin
            w_next = S_CLEAR;
          end else if (w_steps == '0) begin
            w_next = S_DONE;
          end else begin
            w_next = S_RUN;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (r_remaining == '0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // Guarded so the count can never wrap below zero.
        if (r_remaining != '0) begin
          w_remaining = r_remaining - L_ONE;
        end else begin
          w_remaining = '0;
        end
        if (r_remaining <= L_ONE) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and remaining-step counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_remaining;
    end
  end

  // Registered outputs decoded from the upcoming state; completion captures the counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt_clr <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gnt     <= 2'b00;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_result  <= 3'b000;
      r_ovf     <= 1'b0;
    end else begin
      r_cnt_clr <= (w_next == S_CLEAR);
      r_cnt_en  <= (w_next == S_RUN);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (r_state == S_DONE);
      r_gnt     <= w_accept ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
      if (w_accept) begin
        r_owner <= w_idx;
        r_last  <= w_idx;
      end
      if (r_state == S_DONE) begin
        r_result <= GrayIn;
        r_ovf    <= OvfIn;
      end
    end
  end

  assign CntClr  = r_cnt_clr;
  assign CntEn   = r_cnt_en;
  assign Gnt     = r_gnt;
  assign Owner   = r_owner;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Result  = r_result;
  assign OvfFlag = r_ovf;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl: drives a behavioural Gray counter, predicts every output
// cycle-by-cycle from transaction timing, and adds directed literal checks.
module tb_gray_step_ctrl;
  localparam int STEP_W = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Req0 = 1'b0;
  logic              Cmd0 = 1'b0;
  logic [STEP_W-1:0] Steps0 = '0;
  logic              Req1 = 1'b0;
  logic              Cmd1 = 1'b0;
  logic [STEP_W-1:0] Steps1 = '0;
  logic [2:0]        GrayIn;
  logic              OvfIn;
  logic              CntClr, CntEn, Owner, Busy, Done, OvfFlag;
  logic [1:0]        Gnt;
  logic [2:0]        Result;

  int n_vec = 0;
  int n_err = 0;

  gray_step_ctrl #(.STEP_W(STEP_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Cmd0(Cmd0), .Steps0(Steps0),
    .Req1(Req1), .Cmd1(Cmd1), .Steps1(Steps1),
    .GrayIn(GrayIn), .OvfIn(OvfIn),
    .CntClr(CntClr), .CntEn(CntEn), .Gnt(Gnt), .Owner(Owner),
    .Busy(Busy), .Done(Done), .Result(Result), .OvfFlag(OvfFlag)
  );

  always #5 Clk = ~Clk;

  // The shared Gray counter: sync clear, enable, sticky overflow; unaffected by the controller reset.
  logic [2:0] cb = 3'd0;
  logic       covf = 1'b0;
  always @(posedge Clk) begin
    if (CntClr) begin
      cb   <= 3'd0;
      covf <= 1'b0;
    end else if (CntEn) begin
      if (cb == 3'd7) covf <= 1'b1;
      cb <= cb + 3'd1;
    end
  end
  assign GrayIn = cb ^ (cb >> 1);
  assign OvfIn  = covf;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray(input int v);
    int b;
    b = v % 8;
    return b ^ (b >> 1);
  endfunction

  // Transaction-level model: one active command described by its accept edge and length.
  bit m_active = 1'b0;
  bit m_last = 1'b1;
  bit m_owner = 1'b0;
  bit m_idx = 1'b0;
  bit m_cmd = 1'b0;
  int ecnt = 0, m_a = 0, m_total = 0, m_off = 0, m_steps = 0;
  int m_res = 0, m_ovf = 0, m_txn_res = 0, m_txn_ovf = 0;

  initial forever begin
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_owner  = 1'b0;
      m_res    = 0;
      m_ovf    = 0;
    end else begin
      ecnt++;
      if (m_active && (ecnt - m_a == m_total)) begin
        m_res = m_txn_res;
        m_ovf = m_txn_ovf;
      end
      if ((!m_active || (ecnt - m_a > m_total)) && (Req0 || Req1)) begin
        if (Req0 && Req1) m_idx = !m_last;
        else m_idx = Req1;
        m_cmd   = m_idx ? Cmd1 : Cmd0;
        m_steps = m_idx ? int'(Steps1) : int'(Steps0);
        m_off   = m_cmd ? 1 : 0;
        m_total = m_off + m_steps + 1;
        m_a      = ecnt;
        m_active = 1'b1;
        m_last   = m_idx;
        m_owner  = m_idx;
        if (m_cmd) begin
          m_txn_res = gray(m_steps);
          m_txn_ovf = (m_steps >= 8) ? 1 : 0;
        end else begin
          m_txn_res = gray(int'(cb) + m_steps);
          m_txn_ovf = (covf || (int'(cb) + m_steps >= 8)) ? 1 : 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    int t;
    @(negedge Clk);
    t = m_active ? (ecnt - m_a) : -1000;
    check("cmp_gnt",   int'(Gnt),    (t == 0) ? (m_idx ? 2 : 1) : 0);
    check("cmp_busy",  int'(Busy),   (t >= 0 && t < m_total) ? 1 : 0);
    check("cmp_clr",   int'(CntClr), (t == 0 && m_cmd) ? 1 : 0);
    check("cmp_en",    int'(CntEn),  (t >= m_off && t < m_off + m_steps) ? 1 : 0);
    check("cmp_done",  int'(Done),   (t == m_total) ? 1 : 0);
    check("cmp_owner", int'(Owner),  int'(m_owner));
    check("cmp_res",   int'(Result), m_res);
    check("cmp_ovf",   int'(OvfFlag), m_ovf);
  end

  task automatic drive_req(input int i, input bit cmd, input int steps);
    if (i == 0) begin
      Req0 = 1'b1; Cmd0 = cmd; Steps0 = STEP_W'(steps);
    end else begin
      Req1 = 1'b1; Cmd1 = cmd; Steps1 = STEP_W'(steps);
    end
  endtask

  // Issue one command, then measure latency and counter-strobe cycles up to Done.
  task automatic run_cmd(input int i, input bit cmd, input int steps);
    bit seen;
    int lat, n_en, n_clr;
    @(negedge Clk);
    drive_req(i, cmd, steps);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge Clk);
      if (Gnt != 2'b00) seen = 1'b1;
    end
    check("gnt_seen", int'(seen), 1);
    check("gnt_idx", int'(Gnt), (i == 0) ? 1 : 2);
    if (i == 0) Req0 = 1'b0; else Req1 = 1'b0;
    n_en  = int'(CntEn);
    n_clr = int'(CntClr);
    lat   = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge Clk);
      lat++;
      if (Done) begin
        seen = 1'b1;
      end else begin
        n_en  += int'(CntEn);
        n_clr += int'(CntClr);
      end
    end
    check("done_seen", int'(seen), 1);
    // Latency counts the cycle in which the request was sampled.
    check("latency", lat + 1, cmd ? steps + 3 : steps + 2);
    check("cnt_en_cycles", n_en, steps);
    check("cnt_clr_cycles", n_clr, cmd ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pend;
    bit seen;
    repeat (3) @(negedge Clk);
    check("rst_busy", int'(Busy), 0);
    check("rst_gnt", int'(Gnt), 0);
    check("rst_done", int'(Done), 0);
    check("rst_en", int'(CntEn), 0);
    check("rst_clr", int'(CntClr), 0);
    check("rst_result", int'(Result), 0);
    check("rst_owner", int'(Owner), 0);
    Reset = 1'b1;

    run_cmd(0, 1'b1, 5);
    check("t1_result", int'(Result), 3'b111);
    check("t1_ovf", int'(OvfFlag), 0);
    check("t1_owner", int'(Owner), 0);

    run_cmd(1, 1'b0, 4);
    check("t2_result", int'(Result), 3'b001);
    check("t2_ovf", int'(OvfFlag), 1);
    check("t2_owner", int'(Owner), 1);

    // Both requesters continuously pending: grants must alternate starting with 0.
    do_reset();
    @(negedge Clk);
    Cmd0 = 1'b0; Steps0 = STEP_W'(1); Cmd1 = 1'b0; Steps1 = STEP_W'(1);
    Req0 = 1'b1; Req1 = 1'b1;
    pend = -1;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge Clk);
        if (pend == 0) Req0 = 1'b1;
        if (pend == 1) Req1 = 1'b1;
        pend = -1;
        if (Gnt != 2'b00) seen = 1'b1;
      end
      check("rr_seen", int'(seen), 1);
      check("rr_not_both", int'(Gnt == 2'b11), 0);
      check("rr_order", int'(Gnt), (g % 2 == 0) ? 1 : 2);
      if (Gnt[0]) begin Req0 = 1'b0; pend = 0; end
      if (Gnt[1]) begin Req1 = 1'b0; pend = 1; end
    end
    Req0 = 1'b0; Req1 = 1'b0;

    run_cmd(0, 1'b0, 0);
    check("t4_result", int'(Result), int'(GrayIn));
    check("t4_ovf", int'(OvfFlag), int'(OvfIn));

    // Reset on the third RUN cycle abandons the command.
    @(negedge Clk);
    drive_req(0, 1'b1, 10);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge Clk);
      if (Gnt[0]) seen = 1'b1;
    end
    check("t5_gnt", int'(seen), 1);
    Req0 = 1'b0;
    repeat (3) @(negedge Clk);
    check("t5_en_before", int'(CntEn), 1);
    #1 Reset = 1'b0;
    #1;
    check("t5_en_reset", int'(CntEn), 0);
    check("t5_busy_reset", int'(Busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("t5_no_done", int'(Done), 0);
    end
    Reset = 1'b1;
    run_cmd(1, 1'b1, 2);
    check("t5_result", int'(Result), 3'b011);

    run_cmd(0, 1'b1, 15);
    check("t6_result", int'(Result), 3'b100);
    check("t6_ovf", int'(OvfFlag), 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (Req0 && Gnt[0]) begin
        Req0 = 1'b0;
      end else if (!Req0 && $urandom_range(0, 3) == 0) begin
        drive_req(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end
      if (Req1 && Gnt[1]) begin
        Req1 = 1'b0;
      end else if (!Req1 && $urandom_range(0, 3) == 0) begin
        drive_req(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (40) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
